instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage feeding the main control unit and register file: holds the PC, issues word fetches to instruction memory over a request/response handshake, and presents fetched instructions in an IF/ID register whose `ifid_opcode` field drives the control unit's opcode input. Branch redirects from EX (`branch & zero`) flush the stage, and hazard stalls freeze it.

## Interface
- `XLEN`, 32: address and instruction width. Fixed at 32 for RV32I.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset. Must be word-aligned.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high, one clock.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; bits [1:0] are always 00.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response data valid; at most one outstanding request.
- `imem_rdata`  in  32  instruction word.
- `branch_taken`  in  1  redirect request from EX.
- `branch_target`  in  32  redirect address; bits [1:0] are ignored and forced to 00.
- `stall`  in  1  hazard unit holds IF/ID.
- `ifid_valid`  out  1  IF/ID holds a live instruction.
- `ifid_pc`  out  32  PC of the IF/ID instruction.
- `ifid_instr`  out  32  instruction word.
- `ifid_opcode`  out  7  equals `ifid_instr[6:0]`; drives the control unit.

## Operation
- State machine `FETCH`, `WAIT`, `HOLD`, `DRAIN`. Registers: `pc`, a one-entry hold buffer (`hold_instr`, `hold_pc`), and IF/ID.
- **FETCH**
  - `imem_req`=1, `imem_addr`=`pc`.
  - When `imem_ready`=1, latch `fetch_pc`=`pc` and go to `WAIT`.
- **WAIT**
  - `imem_req`=0.
  - On `imem_rvalid` with `stall`=0: load IF/ID (`valid`=1, `pc`=`fetch_pc`, `instr`=`imem_rdata`), set `pc`←`pc`+4, go to `FETCH`.
  - On `imem_rvalid` with `stall`=1: write to the hold buffer, go to `HOLD`.
- **HOLD**
  - `imem_req`=0.
  - When `stall`=0: move the hold buffer into IF/ID, set `pc`←`pc`+4, go to `FETCH`.
- **DRAIN**
  - `imem_req`=0.
  - On `imem_rvalid`, discard the data and go to `FETCH`.
- **IF/ID update rule**
  - `stall`=1: IF/ID holds its value.
  - `stall`=0 and no instruction delivered this cycle: `ifid_valid`←0 (bubble). `ifid_pc` and `ifid_instr` keep their values.
- **Redirect** (`branch_taken`=1) has priority over `stall` and the handshake:
  - `pc`←{`branch_target`[31:2],2'b00}; `ifid_valid`←0; hold buffer invalidated.
  - `WAIT` without `rvalid` → `DRAIN`.
  - `WAIT` with `rvalid` in the same cycle → data discarded, go to `FETCH`.
  - `FETCH` with `imem_ready` in the same cycle → the accepted request is stale; go to `DRAIN`.
  - `FETCH` without `imem_ready` → stay in `FETCH`; `imem_addr` shows the new PC next cycle.
  - `HOLD` → `FETCH`.
  - `DRAIN` → stay in `DRAIN` (no `rvalid`) or go to `FETCH` (`rvalid`).
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- `rst` overrides all other inputs in the same cycle, including a mid-fetch or pending `rvalid`. A response arriving after reset while in `FETCH` is ignored; the memory model must not hold one across reset.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state=`FETCH`.
  - `ifid_valid`=0, `ifid_pc`=0, `ifid_instr`=32'h0000_0013 (NOP), `ifid_opcode`=7'b0010011.
  - Hold buffer invalid.
  - `imem_req`=1 from the first cycle after reset.
- `imem_addr` is held stable while `imem_req`=1 and `imem_ready`=0.
- Latency: request accepted in cycle N, `rvalid` in N+k, `ifid_valid`=1 from N+k+1.
- Best-case throughput is one instruction every 2 cycles (`ready` and 1-cycle `rvalid` always asserted).
- A redirect in cycle N gives `ifid_valid`=0 in N+1. The first fetch of the target issues in N+1 from `FETCH`, or in the cycle after a drain completes.
- `ifid_opcode` is a direct slice of the IF/ID register and adds no logic delay to the control-unit path.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants (R-type 7'b0110011, LW 7'b0000011, SW 7'b0100011, BEQ 7'b1100011, OP-IMM 7'b0010011);
  - `NOP_INSTR`=32'h0000_0013;
  - default `RESET_PC`;
  - the fetch state enum.
- No sub-module; the PC, hold buffer, FSM and IF/ID register live in one module.

## Test plan
- Reset, then `ready`=1 and 1-cycle `rvalid` with memory returning `addr`^32'hA5A5_0000 → `imem_addr` sequence 0,4,8 on every other cycle; `ifid_pc`/`ifid_instr` match each address 2 cycles after its request.
- `stall`=1 for 3 cycles while `rvalid` arrives → the previous IF/ID contents are held and the state is `HOLD`; on release, the held instruction appears in IF/ID the next cycle and the next `imem_addr` is `pc`+4.
- `branch_taken` with target 32'h0000_0102 while in `WAIT`, `rvalid` 2 cycles later → that response is dropped, `ifid_valid`=0, and the next request address is 32'h0000_0100.
- `branch_taken` in the same cycle as `imem_ready` → `DRAIN`; the stale response is discarded and the target is fetched afterwards.
- `branch_taken` and `stall` together while `ifid_valid`=1 → `ifid_valid`=0 next cycle.
- PC at 32'hFFFF_FFFC → the next request is 0. `rst` asserted mid-`WAIT` → `ifid_valid`=0, `ifid_instr`=NOP, first request at `RESET_PC`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, the canonical NOP, default reset vector
// and the fetch-stage state encoding.
package riscv_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  // Instruction addresses are always word aligned; low bits are dropped.
  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage signal bundle: instruction-memory handshake, EX redirect,
// hazard stall and the IF/ID register outputs.
interface instruction_fetch_if #(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            stall;

  logic            ifid_valid;
  logic [XLEN-1:0] ifid_pc;
  logic [XLEN-1:0] ifid_instr;
  logic [6:0]      ifid_opcode;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    input  branch_taken, branch_target, stall,
    output ifid_valid, ifid_pc, ifid_instr, ifid_opcode
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    output branch_taken, branch_target, stall,
    input  ifid_valid, ifid_pc, ifid_instr, ifid_opcode
  );

endinterface

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: PC, single-outstanding imem handshake, one-entry hold
// buffer for responses arriving under stall, and the IF/ID pipeline register.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_fetchPc;
  logic            r_imemReq;

  logic            r_holdValid;
  logic [XLEN-1:0] r_holdPc;
  logic [XLEN-1:0] r_holdInstr;

  logic            r_ifidValid;
  logic [XLEN-1:0] r_ifidPc;
  logic [XLEN-1:0] r_ifidInstr;

  logic [XLEN-1:0] w_redirectPc;
  logic [XLEN-1:0] w_pcNext;

  assign w_redirectPc = wordAlign(bus.branch_target);
  assign w_pcNext     = r_pc + XLEN'(4);

  // A redirect overrides stall and handshake; any response still in flight
  // for the old path is swallowed by DRAIN before the target is requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_fetchPc   <= RESET_PC;
      r_imemReq   <= 1'b1;
      r_holdValid <= 1'b0;
      r_holdPc    <= '0;
      r_holdInstr <= NOP_INSTR;
      r_ifidValid <= 1'b0;
      r_ifidPc    <= '0;
      r_ifidInstr <= NOP_INSTR;
    end else if (bus.branch_taken) begin
      r_pc        <= w_redirectPc;
      r_ifidValid <= 1'b0;
      r_holdValid <= 1'b0;
      case (r_state)
        FETCH: begin
          if (bus.imem_ready) begin
            r_state   <= DRAIN;
            r_imemReq <= 1'b0;
          end else begin
            r_state   <= FETCH;
            r_imemReq <= 1'b1;
          end
        end
        WAIT, DRAIN: begin
          if (bus.imem_rvalid) begin
            r_state   <= FETCH;
            r_imemReq <= 1'b1;
          end else begin
            r_state   <= DRAIN;
            r_imemReq <= 1'b0;
          end
        end
        default: begin
          r_state   <= FETCH;
          r_imemReq <= 1'b1;
        end
      endcase
    end else begin
      case (r_state)
        FETCH: begin
          if (!bus.stall) begin
            r_ifidValid <= 1'b0;
          end
          if (bus.imem_ready) begin
            r_fetchPc <= r_pc;
            r_state   <= WAIT;
            r_imemReq <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid && !bus.stall) begin
            r_ifidValid <= 1'b1;
            r_ifidPc    <= r_fetchPc;
            r_ifidInstr <= bus.imem_rdata;
            r_pc        <= w_pcNext;
            r_state     <= FETCH;
            r_imemReq   <= 1'b1;
          end else if (bus.imem_rvalid) begin
            r_holdValid <= 1'b1;
            r_holdPc    <= r_fetchPc;
            r_holdInstr <= bus.imem_rdata;
            r_state     <= HOLD;
          end else if (!bus.stall) begin
            r_ifidValid <= 1'b0;
          end
        end
        HOLD: begin
          if (!bus.stall) begin
            r_ifidValid <= r_holdValid;
            r_ifidPc    <= r_holdPc;
            r_ifidInstr <= r_holdInstr;
            r_holdValid <= 1'b0;
            r_pc        <= w_pcNext;
            r_state     <= FETCH;
            r_imemReq   <= 1'b1;
          end
        end
        DRAIN: begin
          if (!bus.stall) begin
            r_ifidValid <= 1'b0;
          end
          if (bus.imem_rvalid) begin
            r_state   <= FETCH;
            r_imemReq <= 1'b1;
          end
        end
        default: begin
          r_state   <= FETCH;
          r_imemReq <= 1'b1;
        end
      endcase
    end
  end

  assign bus.imem_req    = r_imemReq;
  assign bus.imem_addr   = r_pc;
  assign bus.ifid_valid  = r_ifidValid;
  assign bus.ifid_pc     = r_ifidPc;
  assign bus.ifid_instr  = r_ifidInstr;
  assign bus.ifid_opcode = r_ifidInstr[6:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: a memory/EX/hazard driver with a
// program-order reference model feeds a scoreboard checked by a monitor.
module tb_instruction_fetch;
  import riscv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetchEntry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int nChecks = 0;
  int nErrors = 0;

  fetchEntry_t expQ[$];
  logic        memBusy     = 1'b0;
  logic        memLive     = 1'b0;
  int          memLat      = 0;
  logic [31:0] memAddr     = '0;
  logic        holdPending = 1'b0;
  logic        expValidNext = 1'b0;
  logic [31:0] reqAddrExp  = RESET_PC;
  int          acceptCount = 0;

  instruction_fetch_if #(.XLEN(32)) ifc ();

  instruction_fetch #(
    .XLEN    (32),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.master)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of environment behaviour, called at a falling edge. The model
  // tracks program order: each accepted request must be the next sequential
  // PC (or the redirect target), and only responses to requests not killed by
  // a later redirect may ever reach IF/ID.
  task automatic applyStimulus(input int pReady, input int pStall, input int pBranch,
                               input int maxLat, input bit forceBranch,
                               input logic [31:0] forceTarget);
    logic        req, rdy, rv, stl, br, load;
    logic [31:0] addr, tgt;
    fetchEntry_t entry;
    req  = ifc.imem_req;
    addr = ifc.imem_addr;
    rv   = memBusy && (memLat == 0);
    if (memBusy && memLat != 0) memLat--;
    rdy = !memBusy && req && (int'($urandom_range(99)) < pReady);
    stl = int'($urandom_range(99)) < pStall;
    br  = forceBranch || (int'($urandom_range(99)) < pBranch);
    tgt = forceBranch ? forceTarget : $urandom;

    ifc.imem_ready    = rdy;
    ifc.imem_rvalid   = rv;
    ifc.imem_rdata    = rv ? (memAddr ^ DATA_KEY) : $urandom;
    ifc.stall         = stl;
    ifc.branch_taken  = br;
    ifc.branch_target = tgt;

    load = !br && !stl && ((rv && memLive) || holdPending);
    if (rv) memBusy = 1'b0;
    if (rv && memLive && !br && stl) holdPending = 1'b1;
    if (load) holdPending = 1'b0;
    if (rdy) begin
      checkOutput("requestAddr", addr, reqAddrExp);
      acceptCount++;
      memBusy = 1'b1;
      memLive = !br;
      memAddr = addr;
      memLat  = int'($urandom_range(maxLat));
      if (!br) begin
        entry.pc    = addr;
        entry.instr = addr ^ DATA_KEY;
        expQ.push_back(entry);
      end
      reqAddrExp = addr + 32'd4;
    end
    if (br) begin
      expQ.delete();
      holdPending = 1'b0;
      memLive     = 1'b0;
      reqAddrExp  = tgt & 32'hFFFF_FFFC;
    end
    expValidNext = br ? 1'b0 : (stl ? expValidNext : load);
  endtask

  // Called at a falling edge; holds reset for one clock and checks the
  // architectural reset state. The memory forgets any outstanding request.
  task automatic applyReset();
    rst               = 1'b1;
    ifc.imem_ready    = 1'b0;
    ifc.imem_rvalid   = 1'b0;
    ifc.imem_rdata    = '0;
    ifc.stall         = 1'b0;
    ifc.branch_taken  = 1'b0;
    ifc.branch_target = '0;
    expQ.delete();
    memBusy      = 1'b0;
    memLive      = 1'b0;
    holdPending  = 1'b0;
    expValidNext = 1'b0;
    reqAddrExp   = RESET_PC;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("resetIfidValid", 32'(ifc.ifid_valid), 32'd0);
    checkOutput("resetIfidPc", ifc.ifid_pc, 32'd0);
    checkOutput("resetIfidInstr", ifc.ifid_instr, NOP_INSTR);
    checkOutput("resetOpcode", 32'(ifc.ifid_opcode), 32'(OPC_OPIMM));
    checkOutput("resetImemReq", 32'(ifc.imem_req), 32'd1);
    checkOutput("resetImemAddr", ifc.imem_addr, RESET_PC);
  endtask

  // Monitor: every cycle IF/ID valid must follow the model; a fresh load pops
  // the scoreboard, a stalled valid entry must still show the last one popped.
  initial begin
    fetchEntry_t last;
    logic sRst, sStall, sExp;
    last = '0;
    forever begin
      @(posedge clk);
      sRst   = rst;
      sStall = ifc.stall;
      sExp   = expValidNext;
      #1;
      if (!sRst) begin
        checkOutput("ifidValid", 32'(ifc.ifid_valid), 32'(sExp));
        if (sExp) begin
          if (!sStall) begin
            if (expQ.size() == 0) begin
              nChecks++;
              nErrors++;
              $display("[TB] FAIL scoreboard: IF/ID pc %h loaded, expected no instruction", ifc.ifid_pc);
            end else begin
              last = expQ.pop_front();
            end
          end
          checkOutput("ifidPc", ifc.ifid_pc, last.pc);
          checkOutput("ifidInstr", ifc.ifid_instr, last.instr);
          checkOutput("ifidOpcode", 32'(ifc.ifid_opcode), 32'(last.instr[6:0]));
        end
      end
    end
  end

  initial begin
    bit found;
    ifc.imem_ready    = 1'b0;
    ifc.imem_rvalid   = 1'b0;
    ifc.imem_rdata    = '0;
    ifc.stall         = 1'b0;
    ifc.branch_taken  = 1'b0;
    ifc.branch_target = '0;
    @(negedge clk);
    applyReset();

    // Best case: ready always, one-cycle response -> one request every 2 cycles.
    @(negedge clk);
    acceptCount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      applyStimulus(100, 0, 0, 0, 1'b0, 32'h0);
    end
    checkOutput("throughputAccepts", 32'(acceptCount), 32'd10);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      applyStimulus(60, 30, 6, 3, 1'b0, 32'h0);
    end

    // Redirect to a misaligned target while a live request is outstanding.
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!found && memBusy && memLive && memLat != 0) begin
        applyStimulus(100, 0, 0, 2, 1'b1, 32'h0000_0102);
        found = 1'b1;
      end else begin
        applyStimulus(100, 0, 0, 2, 1'b0, 32'h0);
      end
    end
    checkOutput("redirectInWaitSeen", 32'(found), 32'd1);

    // Redirect in the very cycle the request is accepted.
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!found && ifc.imem_req && !memBusy) begin
        applyStimulus(100, 0, 0, 2, 1'b1, 32'h0000_0040);
        found = 1'b1;
      end else begin
        applyStimulus(100, 20, 0, 2, 1'b0, 32'h0);
      end
    end
    checkOutput("redirectOnAcceptSeen", 32'(found), 32'd1);

    // Redirect together with stall while IF/ID holds a live instruction.
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!found && expValidNext) begin
        applyStimulus(100, 100, 0, 1, 1'b1, 32'h0000_0200);
        found = 1'b1;
      end else begin
        applyStimulus(100, 0, 0, 1, 1'b0, 32'h0);
      end
    end
    checkOutput("redirectWithStallSeen", 32'(found), 32'd1);

    // PC wrap: target at the top of the address space.
    @(negedge clk);
    applyStimulus(100, 0, 0, 0, 1'b1, 32'hFFFF_FFFE);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      applyStimulus(100, 10, 0, 1, 1'b0, 32'h0);
    end

    // Reset while a request is outstanding.
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (memBusy && memLive) begin
        found = 1'b1;
        applyReset();
      end else begin
        applyStimulus(100, 0, 0, 3, 1'b0, 32'h0);
      end
    end
    checkOutput("resetInWaitSeen", 32'(found), 32'd1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      applyStimulus(80, 20, 0, 2, 1'b0, 32'h0);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule
